// File: rtl/gcd_host_pkg.sv
// Shared definitions for the GCD host-side job controller.
//   GCD_WIDTH   : default operand/result width
//   gcd_state_t : controller FSM states
package gcd_host_pkg;

  localparam int GCD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } gcd_state_t;

endpackage

// File: rtl/gcd_settle_detect.sv
// Result settle detector: watches a polled result register and reports when it
// has held the same value for STABLE_CYCLES consecutive enabled cycles.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero the stable count and take a fresh reference sample
//   enable     : compare/update this cycle
//   result     : value being polled
//   stable     : stable count has reached STABLE_CYCLES
module gcd_settle_detect
  import gcd_host_pkg::*;
#(
  parameter int WIDTH         = GCD_WIDTH,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] result,
  output logic             stable
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] prev_result;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_result <= '0;
      stable_cnt  <= '0;
    end else if (clear) begin
      // Reference sample taken while clearing, so the first enabled cycle
      // compares against a meaningful value.
      prev_result <= result;
      stable_cnt  <= '0;
    end else if (enable) begin
      prev_result <= result;
      if (result != prev_result) begin
        stable_cnt <= '0;
      end else if (stable_cnt < CNT_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign stable = (stable_cnt >= CNT_MAX);

endmodule

// File: rtl/gcd_host_ctrl.sv
// Host-side GCD job controller in front of the CPU. Accepts (a, b) requests,
// drives the CPU operand/start inputs, declares completion once gcd_result has
// settled (or a timeout expires) and returns the result on a response channel.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake, req_a/req_b operands
//   rsp_valid/rsp_ready    : response handshake, rsp_result, rsp_timeout
//   busy                   : controller is not idle
//   calc_start, gcd_a/b    : to CPU
//   gcd_result             : from CPU
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE. rsp_valid is high only in DONE and
// rsp_result/rsp_timeout are registered and held until the transfer; nothing
// on the response side depends combinationally on rsp_ready.
module gcd_host_ctrl
  import gcd_host_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int START_CYCLES   = 4,
  parameter int MIN_RUN_CYCLES = 32,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             calc_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic [WIDTH-1:0] gcd_result
);

  localparam int START_W = $clog2(START_CYCLES) + 1;
  localparam int RUN_W   = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_MIN    = RUN_W'(MIN_RUN_CYCLES);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_MAX    = '1;

  gcd_state_t         state;
  gcd_state_t         state_next;
  logic [START_W-1:0] start_cnt;
  logic [RUN_W-1:0]   run_cnt;
  // A zero operand skips the CPU: the job passes through one RUN cycle that
  // only latches a|b, which gives the two-cycle accept-to-response latency.
  logic               bypass_q;
  logic               stable;
  logic               run_done;
  logic               run_timeout;

  gcd_settle_detect #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_START),
    .enable ((state == ST_RUN) && !bypass_q),
    .result (gcd_result),
    .stable (stable)
  );

  // The MIN_RUN_CYCLES gate masks a result register that still holds the
  // previous job's answer and therefore looks settled straight away.
  assign run_done    = (run_cnt >= RUN_MIN) && stable;
  assign run_timeout = (run_cnt == RUN_LAST);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = ((req_a == '0) || (req_b == '0)) ? ST_RUN : ST_START;
        end
      end
      ST_START: begin
        if (start_cnt == START_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bypass_q || run_done || run_timeout) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      start_cnt   <= '0;
      run_cnt     <= '0;
      bypass_q    <= 1'b0;
      gcd_a       <= '0;
      gcd_b       <= '0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          // gcd_a/gcd_b change only here, so CPU inputs stay put for the job.
          if (req_valid) begin
            gcd_a     <= req_a;
            gcd_b     <= req_b;
            bypass_q  <= (req_a == '0) || (req_b == '0);
            start_cnt <= '0;
            run_cnt   <= '0;
          end
        end
        ST_START: begin
          run_cnt <= '0;
          if (start_cnt != START_LAST) start_cnt <= start_cnt + 1'b1;
        end
        ST_RUN: begin
          if (bypass_q) begin
            rsp_result  <= gcd_a | gcd_b;
            rsp_timeout <= 1'b0;
          end else if (run_done) begin
            // Normal completion takes priority over a coincident timeout.
            rsp_result  <= gcd_result;
            rsp_timeout <= 1'b0;
          end else if (run_timeout) begin
            rsp_result  <= gcd_result;
            rsp_timeout <= 1'b1;
          end
          if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
        end
        ST_DONE: begin
          if (rsp_ready) bypass_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign calc_start = (state == ST_START);

endmodule

// File: tb/tb_gcd_host_ctrl.sv
// Bench for gcd_host_ctrl with a behavioural CPU model driving gcd_result.
module tb_gcd_host_ctrl;

  localparam int W       = 32;
  localparam int TIMEOUT = 4096;
  localparam logic [W-1:0] TOG_A = 32'd100;
  localparam logic [W-1:0] TOG_B = 32'd200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_timeout;
  logic         busy;
  logic         calc_start;
  logic [W-1:0] gcd_a;
  logic [W-1:0] gcd_b;
  logic [W-1:0] gcd_result = '0;

  gcd_host_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .calc_start  (calc_start),
    .gcd_a       (gcd_a),
    .gcd_b       (gcd_b),
    .gcd_result  (gcd_result)
  );

  // ---------------- reference ----------------
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    if (a == '0 || b == '0) return a | b;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // ---------------- CPU model ----------------
  // After the start burst ends, the model waits model_delay cycles (emitting
  // junk values if noise_en) and then presents gcd(gcd_a, gcd_b). set_cyc is
  // the cycle of that last change. toggle_mode flips the result every 8 cycles.
  int           model_delay = 10;
  bit           noise_en    = 1'b1;
  bit           toggle_mode = 1'b0;
  int           stale_id    = 0;
  logic [W-1:0] stale_val   = '0;
  int           stale_seen  = 0;
  bit           armed       = 1'b0;
  int           cd          = 0;
  int           set_cyc     = -100;
  logic [W-1:0] last_val    = '0;

  always @(negedge clk) begin
    last_val = gcd_result;
    if (stale_id != stale_seen) begin
      stale_seen = stale_id;
      gcd_result = stale_val;
    end else if (toggle_mode) begin
      if (cyc % 8 == 0) gcd_result = (gcd_result == TOG_A) ? TOG_B : TOG_A;
    end else if (calc_start === 1'b1) begin
      armed = 1'b1;
      cd    = 0;
    end else if (armed) begin
      armed = 1'b0;
      cd    = model_delay;
      if (noise_en) gcd_result = $urandom | 32'h8000_0000;
    end else if (cd > 1) begin
      cd--;
      if (noise_en) gcd_result = $urandom | 32'h8000_0000;
    end else if (cd == 1) begin
      cd         = 0;
      gcd_result = gcd_ref(gcd_a, gcd_b);
      set_cyc    = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  bit after_rsp = 1'b0;
  int last_hs   = 0;
  int last_acc  = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Presents a request from the current cycle; returns the accept cycle and
  // leaves the bench one cycle after it with req_valid dropped.
  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int guard;
    guard     = 0;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: req_ready=%b after %0d cycles, want 1", req_ready, guard);
    end
    acc = cyc;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit to_exp, input bit pend, input logic [W-1:0] pa,
                         input logic [W-1:0] pb, input string tag);
    int acc;
    int rsp_cyc;
    int exp_cyc;
    int n;
    int cs_cnt;
    int cs_first;
    bit hold_bad;
    bit bypass;
    logic [W-1:0] held;
    logic [W-1:0] exp_r;
    n        = 0;
    cs_cnt   = 0;
    cs_first = -1;
    hold_bad = 1'b0;
    bypass   = (a == '0) || (b == '0);
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    if (after_rsp) begin
      after_rsp = 1'b0;
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL %s post_handshake: rsp_valid,req_ready=%b want 01", tag, {rsp_valid, req_ready});
      end
    end
    send_req(a, b, acc);
    last_acc = acc;
    if (!to_exp) exp_q.push_back(gcd_ref(a, b));
    checks++;
    if (gcd_a !== a || gcd_b !== b) begin
      errors++;
      $display("FAIL %s operands: gcd_a=%0d gcd_b=%0d want %0d %0d", tag, gcd_a, gcd_b, a, b);
    end
    while (rsp_valid !== 1'b1 && n < 5000) begin
      if (calc_start === 1'b1) begin
        if (cs_first < 0) cs_first = cyc;
        cs_cnt++;
      end
      @(negedge clk); #1;
      n++;
    end
    rsp_cyc = cyc;
    if (bypass)      exp_cyc = acc + 2;
    else if (to_exp) exp_cyc = acc + 5 + TIMEOUT;
    else             exp_cyc = (set_cyc + 18 > acc + 38) ? set_cyc + 18 : acc + 38;
    checks++;
    if (rsp_cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s latency: rsp_valid at +%0d cycles, want +%0d", tag, rsp_cyc - acc, exp_cyc - acc);
    end
    checks++;
    if (bypass ? (cs_cnt != 0) : (cs_cnt != 4 || cs_first != acc + 1)) begin
      errors++;
      $display("FAIL %s start_burst: %0d cycles from +%0d, want %0d from +1", tag, cs_cnt,
               cs_first - acc, bypass ? 0 : 4);
    end
    if (to_exp) exp_q.push_back(last_val);
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      if (pend) begin
        req_valid = 1'b1;
        req_a     = pa;
        req_b     = pb;
      end
      @(negedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_result !== held || req_ready !== 1'b0 || gcd_a !== a)
        hold_bad = 1'b1;
    end
    if (hold > 0) begin
      checks++;
      if (hold_bad) begin
        errors++;
        $display("FAIL %s hold: rsp_valid=%b result=%0d req_ready=%b gcd_a=%0d, want 1 %0d 0 %0d",
                 tag, rsp_valid, rsp_result, req_ready, gcd_a, held, a);
      end
    end
    rsp_ready = 1'b1;
    exp_r = exp_q.pop_front();
    checks++;
    if (rsp_result !== exp_r) begin
      errors++;
      $display("FAIL %s result: got %0d want %0d", tag, rsp_result, exp_r);
    end
    checks++;
    if (rsp_timeout !== to_exp) begin
      errors++;
      $display("FAIL %s timeout_flag: got %b want %b", tag, rsp_timeout, to_exp);
    end
    after_rsp = 1'b1;
    last_hs   = cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({req_ready, rsp_valid, busy, calc_start, rsp_timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL %s flags: ready,valid,busy,start,timeout=%b want 10000", tag,
               {req_ready, rsp_valid, busy, calc_start, rsp_timeout});
    end
    checks++;
    if (gcd_a !== '0 || gcd_b !== '0) begin
      errors++;
      $display("FAIL %s operands: gcd_a=%0d gcd_b=%0d want 0 0", tag, gcd_a, gcd_b);
    end
    checks++;
    if (rsp_result !== '0) begin
      errors++;
      $display("FAIL %s rsp_result: got %0d want 0", tag, rsp_result);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk); #1;
    check_idle_outputs("after_reset");
  endtask

  task automatic test_basic();
    noise_en    = 1'b1;
    model_delay = 10;
    run_job(60, 24, 0, 1'b0, 1'b0, '0, '0, "basic_60_24");
  endtask

  task automatic test_bypass();
    run_job(0, 7, 0, 1'b0, 1'b0, '0, '0, "bypass_0_7");
    run_job(0, 0, 2, 1'b0, 1'b0, '0, '0, "bypass_0_0");
    run_job(9, 0, 0, 1'b0, 1'b0, '0, '0, "bypass_9_0");
  endtask

  task automatic test_backpressure();
    int h;
    model_delay = 20;
    run_job(48, 18, 50, 1'b0, 1'b1, 99, 33, "backpressure");
    h = last_hs;
    model_delay = 5;
    run_job(99, 33, 0, 1'b0, 1'b0, '0, '0, "queued_req");
    checks++;
    if (last_acc != h + 1) begin
      errors++;
      $display("FAIL queued_accept: accepted +%0d after handshake, want +1", last_acc - h);
    end
  endtask

  task automatic test_stale_result();
    @(negedge clk); #1;
    stale_val = 12;
    stale_id++;
    noise_en    = 1'b0;
    model_delay = 25;
    run_job(21, 14, 0, 1'b0, 1'b0, '0, '0, "stale_21_14");
    noise_en = 1'b1;
  endtask

  task automatic test_reset_in_run();
    int acc;
    @(negedge clk); #1;
    rsp_ready   = 1'b0;
    after_rsp   = 1'b0;
    model_delay = 30;
    send_req(77, 21, acc);
    while (cyc < acc + 12) begin
      @(negedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || calc_start !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL in_run: busy,start,valid=%b want 100", {busy, calc_start, rsp_valid});
    end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("abort");
    model_delay = 8;
    run_job(15, 10, 1, 1'b0, 1'b0, '0, '0, "after_abort_15_10");
  endtask

  task automatic test_random_jobs();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
      model_delay = $urandom_range(1, 40);
      run_job(a, b, $urandom_range(0, 4), 1'b0, 1'b0, '0, '0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_timeout();
    toggle_mode = 1'b1;
    run_job(35, 10, 0, 1'b1, 1'b0, '0, '0, "timeout");
    toggle_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_stale_result();
    test_reset_in_run();
    test_random_jobs();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
